imem_arbiter: RTL and testbench

Shares the single-port synchronous instruction memory between the core fetch unit and the program loader/debug port. Each cycle it grants at most one requester, drives the memory port, and returns the read data (or a write acknowledge) to the granted requester one cycle later. Fetch has priority, with a starvation limit that guarantees loader progress, and a boot hold that blocks fetch while a program is being loaded.

---
 rtl/imem_arbiter_if.sv | 61 ++++++
 rtl/imem_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
//   Bundles every signal between the instruction-memory arbiter and its
//   surroundings except clock and reset.
//
//   Fetch port : f_req_valid/addr -> f_req_ready ; f_rsp_valid/data/err
//   Loader port: l_req_valid/we/addr/wdata -> l_req_ready ; l_rsp_valid/data/err
//   Memory port: mem_en/we/addr/wdata -> memory ; mem_rdata <- memory
//   boot_hold  : blocks fetch grants while a program is being loaded
//
//   Modports:
//     slave  - the arbiter side
//     master - the environment side (fetch unit, loader and memory)
// -----------------------------------------------------------------------------
interface imem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              boot_hold;

    logic              f_req_valid;
    logic [31:0]       f_req_addr;
    logic              f_req_ready;
    logic              f_rsp_valid;
    logic [31:0]       f_rsp_data;
    logic              f_rsp_err;

    logic              l_req_valid;
    logic              l_req_we;
    logic [31:0]       l_req_addr;
    logic [31:0]       l_req_wdata;
    logic              l_req_ready;
    logic              l_rsp_valid;
    logic [31:0]       l_rsp_data;
    logic              l_rsp_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  boot_hold,
        input  f_req_valid, f_req_addr,
        output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
        input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output boot_hold,
        output f_req_valid, f_req_addr,
        input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
        output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//   Shares one single-port synchronous instruction memory between the core
//   fetch unit and the program loader / debug port. At most one request is
//   granted per cycle; the memory is driven in the grant cycle and the
//   response (read data, write ack or error) pulses one cycle later.
//   Fetch wins ties, except that after STARVE_LIMIT consecutive fetch grants
//   with the loader waiting the loader is granted. boot_hold blocks fetch.
//
//   Parameters:
//     ADDR_W       word-address width of the memory (2^ADDR_W words)
//     STARVE_LIMIT max consecutive fetch grants while the loader waits (1..15)
//
//   Ports:
//     clk   clock, all state on the rising edge
//     rst_n asynchronous active-low reset
//     bus   imem_arbiter_if.slave (fetch, loader and memory ports)
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_t      rsp_owner_reg, rsp_owner_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        rsp_rd_reg, rsp_rd_next;     // response carries memory read data
    logic [3:0]  starve_cnt_reg, starve_cnt_next;

    logic        f_elig;
    logic        grant_f, grant_l, grant_any;
    logic [31:0] sel_addr;
    logic        sel_err;
    logic        sel_we;

    // Out-of-range or misaligned byte addresses never reach the memory.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
    endfunction

    // ---------------- arbitration and request path ----------------
    always_comb begin
        f_elig    = bus.f_req_valid && !bus.boot_hold;
        grant_l   = bus.l_req_valid && (!f_elig || (starve_cnt_reg == LIMIT));
        grant_f   = f_elig && !grant_l;
        grant_any = grant_f || grant_l;
        sel_addr  = grant_l ? bus.l_req_addr : bus.f_req_addr;
        sel_err   = addr_bad(sel_addr);
        sel_we    = grant_l && bus.l_req_we;
    end

    // Outputs are forced low while reset is asserted; the internal grant
    // terms stay ungated so reset only touches the output stage.
    always_comb begin
        bus.f_req_ready = rst_n && grant_f;
        bus.l_req_ready = rst_n && grant_l;
        bus.mem_en      = rst_n && grant_any && !sel_err;
        bus.mem_we      = bus.mem_en && sel_we;
        bus.mem_addr    = bus.mem_en ? sel_addr[ADDR_W+1:2] : '0;
        bus.mem_wdata   = (bus.mem_en && grant_l) ? bus.l_req_wdata : 32'd0;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        rsp_owner_next  = OWN_NONE;
        rsp_err_next    = 1'b0;
        rsp_rd_next     = 1'b0;
        starve_cnt_next = starve_cnt_reg;

        if (grant_l) begin
            rsp_owner_next = OWN_LOADER;
        end else if (grant_f) begin
            rsp_owner_next = OWN_FETCH;
        end
        rsp_err_next = grant_any && sel_err;
        rsp_rd_next  = grant_any && !sel_err && !sel_we;

        // The count cannot pass LIMIT: at LIMIT a waiting loader wins.
        if (!bus.l_req_valid || grant_l) begin
            starve_cnt_next = 4'd0;
        end else if (grant_f) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner_reg  <= OWN_NONE;
            rsp_err_reg    <= 1'b0;
            rsp_rd_reg     <= 1'b0;
            starve_cnt_reg <= 4'd0;
        end else begin
            rsp_owner_reg  <= rsp_owner_next;
            rsp_err_reg    <= rsp_err_next;
            rsp_rd_reg     <= rsp_rd_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // ---------------- response path ----------------
    // Read data comes straight from the memory, which registers its output
    // one cycle after mem_en.
    always_comb begin
        bus.f_rsp_valid = (rsp_owner_reg == OWN_FETCH);
        bus.f_rsp_err   = bus.f_rsp_valid && rsp_err_reg;
        bus.f_rsp_data  = (bus.f_rsp_valid && rsp_rd_reg) ? bus.mem_rdata : 32'd0;
        bus.l_rsp_valid = (rsp_owner_reg == OWN_LOADER);
        bus.l_rsp_err   = bus.l_rsp_valid && rsp_err_reg;
        bus.l_rsp_data  = (bus.l_rsp_valid && rsp_rd_reg) ? bus.mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//   Self-checking bench for imem_arbiter: directed scenarios followed by
//   randomized traffic, all checked cycle by cycle against a transaction-level
//   reference model (grant rule, starvation count, word array, pending
//   response). A behavioural synchronous RAM sits on the memory port.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int ADDR_W       = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int WORDS        = 1 << ADDR_W;

    logic clk;
    logic rst_n;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [31:0] word_init(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // Behavioural single-port synchronous RAM (registered read).
    logic [31:0] ram [WORDS];
    initial begin
        for (int i = 0; i < WORDS; i++) ram[i] = word_init(i);
        bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata     <= ram[bus.mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [WORDS];
    int          model_cnt = 0;
    bit          pend_f = 0, pend_l = 0, pend_err = 0;
    logic [31:0] pend_data = 0;
    bit          obs_fready, obs_lready;

    // One cycle: drive at the falling edge, check just after, advance model.
    task automatic run_cycle(input bit rst_v, input bit bh,
                             input bit fv, input logic [31:0] fa,
                             input bit lv, input bit lwe,
                             input logic [31:0] la, input logic [31:0] lw);
        bit          fe, gf, gl, bad, en;
        logic [31:0] a;
        int          w;
        @(negedge clk);
        rst_n           = rst_v;
        bus.boot_hold   = bh;
        bus.f_req_valid = fv;
        bus.f_req_addr  = fa;
        bus.l_req_valid = lv;
        bus.l_req_we    = lwe;
        bus.l_req_addr  = la;
        bus.l_req_wdata = lw;
        #1;
        if (!rst_v) begin
            pend_f = 0; pend_l = 0; pend_err = 0; pend_data = 0; model_cnt = 0;
        end
        fe = fv && !bh;
        gf = 0; gl = 0;
        if (rst_v) begin
            if (fe && lv) begin
                if (model_cnt == STARVE_LIMIT) gl = 1; else gf = 1;
            end else if (fe) gf = 1;
            else if (lv)     gl = 1;
        end
        a   = gl ? la : fa;
        bad = (a % 4 != 0) || (a >= 32'(4 * WORDS));
        en  = (gf || gl) && !bad;
        w   = int'(a / 4) % WORDS;

        obs_fready = bus.f_req_ready;
        obs_lready = bus.l_req_ready;
        check("f_req_ready", 32'(bus.f_req_ready), 32'(gf));
        check("l_req_ready", 32'(bus.l_req_ready), 32'(gl));
        check("mem_en",      32'(bus.mem_en),      32'(en));
        if (en) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(w));
            check("mem_we",   32'(bus.mem_we),   32'(gl && lwe));
            if (gl && lwe) check("mem_wdata", bus.mem_wdata, lw);
        end
        check("f_rsp_valid", 32'(bus.f_rsp_valid), 32'(pend_f));
        check("f_rsp_err",   32'(bus.f_rsp_err),   32'(pend_f && pend_err));
        check("f_rsp_data",  bus.f_rsp_data,       pend_f ? pend_data : 32'd0);
        check("l_rsp_valid", 32'(bus.l_rsp_valid), 32'(pend_l));
        check("l_rsp_err",   32'(bus.l_rsp_err),   32'(pend_l && pend_err));
        check("l_rsp_data",  bus.l_rsp_data,       pend_l ? pend_data : 32'd0);
        check("starve_cnt",  32'(dut.starve_cnt_reg), 32'(model_cnt));

        // Advance the model by one transaction.
        pend_f    = gf;
        pend_l    = gl;
        pend_err  = (gf || gl) && bad;
        pend_data = (en && !(gl && lwe)) ? ref_mem[w] : 32'd0;
        if (en && gl && lwe) ref_mem[w] = lw;
        if (!rst_v || !lv || gl) model_cnt = 0;
        else if (gf)             model_cnt = model_cnt + 1;
        $display("[TB] t=%0t rst_n=%0b gf=%0b gl=%0b addr=0x%08h err=%0b cnt=%0d",
                 $time, rst_v, gf, gl, a, bad && (gf || gl), model_cnt);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return ($urandom_range(0, 255) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'(4 * WORDS) + ($urandom_range(0, 1023) << 2);
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = word_init(i);
        rst_n           = 1'b0;
        bus.boot_hold   = 1'b0;
        bus.f_req_valid = 1'b0;
        bus.f_req_addr  = 32'd0;
        bus.l_req_valid = 1'b0;
        bus.l_req_we    = 1'b0;
        bus.l_req_addr  = 32'd0;
        bus.l_req_wdata = 32'd0;

        // Reset with both valids high: everything quiet.
        run_cycle(0, 0, 1, 32'h0, 1, 0, 32'h4, 32'h0);
        run_cycle(0, 0, 1, 32'h0, 1, 0, 32'h4, 32'h0);
        // First cycle after release: fetch wins.
        run_cycle(1, 0, 1, 32'h0, 1, 0, 32'h4, 32'h0);
        check("release_f_ready", 32'(obs_fready), 32'd1);
        check("release_l_ready", 32'(obs_lready), 32'd0);
        run_cycle(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // boot_hold: loader writes then reads word 0, fetch never granted.
        run_cycle(1, 1, 1, 32'h8, 1, 1, 32'h0, 32'h0000_0013);
        run_cycle(1, 1, 1, 32'h8, 1, 0, 32'h0, 32'h0);
        run_cycle(1, 1, 1, 32'h8, 0, 0, 32'h0, 32'h0);
        check("boot_read_data", bus.l_rsp_data, 32'h0000_0013);
        check("boot_f_ready",   32'(obs_fready), 32'd0);

        // Continuous contention: F,F,F,F,L repeating.
        for (int i = 0; i < 15; i++) begin
            run_cycle(1, 0, 1, 32'(i) << 2, 1, 0, 32'h10, 32'h0);
            check("starve_pattern", 32'(obs_lready), 32'(i % 5 == 4));
        end
        run_cycle(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Erroneous fetches: misaligned and out of range.
        run_cycle(1, 0, 1, 32'h2,   0, 0, 32'h0, 32'h0);
        run_cycle(1, 0, 1, 32'h400, 0, 0, 32'h0, 32'h0);
        check("err_f_rsp_err", 32'(bus.f_rsp_err), 32'd1);
        run_cycle(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("err2_f_rsp_err", 32'(bus.f_rsp_err), 32'd1);

        // Back-to-back fetch stream.
        run_cycle(1, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        run_cycle(1, 0, 1, 32'h4, 0, 0, 32'h0, 32'h0);
        run_cycle(1, 0, 1, 32'h8, 0, 0, 32'h0, 32'h0);
        run_cycle(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        check("stream_last_data", bus.f_rsp_data, word_init(2));

        // Loader write immediately followed by a fetch of the same word.
        run_cycle(1, 0, 0, 32'h0,  1, 1, 32'h40, 32'hDEAD_BEEF);
        run_cycle(1, 0, 1, 32'h40, 0, 0, 32'h0,  32'h0);
        run_cycle(1, 0, 0, 32'h0,  0, 0, 32'h0,  32'h0);
        check("raw_fetch_data", bus.f_rsp_data, 32'hDEAD_BEEF);

        // Reset right after a grant drops the response.
        run_cycle(1, 0, 1, 32'h8, 1, 0, 32'h10, 32'h0);
        run_cycle(0, 0, 1, 32'h8, 1, 0, 32'h10, 32'h0);
        run_cycle(1, 0, 0, 32'h0, 0, 0, 32'h0,  32'h0);
        check("post_reset_no_rsp", 32'(bus.f_rsp_valid || bus.l_rsp_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            run_cycle(1, ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 3) != 0), rand_addr(),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                      rand_addr(), $urandom);
        end
        run_cycle(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
